// File: rtl/window_ctrl.sv
// Occupancy-based sequencer for the 3x3 sliding-window line FIFOs (A: row n-1, B: row n-2).
// Optional border reporting is enabled with the WIN_CTRL_BORDER_EN macro.
module window_ctrl #(
  parameter int IMG_W    = 100,
  parameter int IMG_H    = 100,
  parameter int LB_DEPTH = 97
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  output logic                     fa_wr,
  output logic                     fa_rd,
  output logic                     fb_wr,
  output logic                     fb_rd,
  input  logic                     fa_full,
  input  logic                     fb_full,
  input  logic                     fa_empty,
  input  logic                     fb_empty,
  output logic                     fifo_clr,
  output logic [$clog2(IMG_W)-1:0] col,
  output logic [$clog2(IMG_H)-1:0] row,
  output logic                     win_valid,
  output logic [8:0]               border_mask,
  output logic                     frame_done,
  output logic                     err
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int NW = $clog2(LB_DEPTH + 1);

  // Handshake: a pixel transfers (fire) in any cycle where pix_valid and pix_ready are both high.
  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_RUN} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   in_col;
  logic [RW-1:0]   in_row;
  logic [NW-1:0]   a_cnt, b_cnt;
  logic            fire, a_at_depth, b_at_depth, last_pix, win_d;

  always_ff @(posedge clk) begin
    if (rst) state <= S_CLEAR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: state_nxt = S_IDLE;
      S_IDLE:  if (en) state_nxt = S_RUN;
      S_RUN:   if (last_pix) state_nxt = S_CLEAR;
      default: state_nxt = S_CLEAR;
    endcase
  end

  always_comb begin
    pix_ready = 1'b0;
    fifo_clr  = 1'b0;
    case (state)
      S_CLEAR: fifo_clr  = 1'b1;
      S_RUN:   pix_ready = 1'b1;
      default: ;
    endcase
  end

  assign fire       = pix_valid & pix_ready;
  assign a_at_depth = (a_cnt == NW'(LB_DEPTH));
  assign b_at_depth = (b_cnt == NW'(LB_DEPTH));
  assign last_pix   = fire && (in_row == RW'(IMG_H - 1)) && (in_col == CW'(IMG_W - 1));

  // A FIFO at its depth streams: each new write is matched by a read, so counters saturate.
  assign fa_wr = fire;
  assign fa_rd = fire & a_at_depth;
  assign fb_wr = fire & a_at_depth;
  assign fb_rd = fire & b_at_depth;

  // in_col/in_row address the next pixel to be accepted; col/row report the last accepted one.
  always_ff @(posedge clk) begin
    if (rst || state == S_CLEAR) begin
      a_cnt  <= '0;
      b_cnt  <= '0;
      in_col <= '0;
      in_row <= '0;
      col    <= '0;
      row    <= '0;
    end else if (fire) begin
      if (!fa_rd)         a_cnt <= a_cnt + 1'b1;
      if (fb_wr && !fb_rd) b_cnt <= b_cnt + 1'b1;
      col <= in_col;
      row <= in_row;
      if (in_col == CW'(IMG_W - 1)) begin
        in_col <= '0;
        in_row <= (in_row == RW'(IMG_H - 1)) ? '0 : in_row + 1'b1;
      end else begin
        in_col <= in_col + 1'b1;
      end
    end
  end

`ifdef WIN_CTRL_BORDER_EN
  logic [8:0] tap_out;

  // Tap o(i+1)(j+1) sits (2-i) rows up and (2-j) columns left of the accepted pixel.
  always_comb begin
    tap_out = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        tap_out[3*i+j] = (int'(in_row) < 2 - i) || (int'(in_col) < 2 - j);
      end
    end
  end

  assign win_d = 1'b1;

  always_ff @(posedge clk) begin
    if (rst)       border_mask <= '0;
    else if (fire) border_mask <= tap_out;
  end
`else
  assign win_d       = (int'(in_row) >= 2) && (int'(in_col) >= 2);
  assign border_mask = '0;
`endif

  // err survives frame restarts; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      win_valid  <= fire & win_d;
      frame_done <= last_pix;
      if ((fa_wr && fa_full) || (fa_rd && fa_empty) || (fb_wr && fb_full) || (fb_rd && fb_empty))
        err <= 1'b1;
    end
  end
endmodule
